decode_stage: RTL and testbench

Registered, handshaked RV32I decode stage between fetch and execute. It replaces the purely combinational decoder with a valid/ready pipeline stage that includes a one-entry skid buffer, flush support, illegal-instruction flagging, x0 write suppression and optional CSR/SYSTEM decode. Decoding is combinational on the input beat; the stage registers and buffers the decoded result.

---
 rtl/decode_stage_pkg.sv | 79 +++++++
 rtl/decode_ctrl.sv | 138 +++++++++++++
 rtl/decode_stage.sv | 121 ++++++++++++
 tb/tb_decode_stage.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared definitions for the RV32I decode stage: opcodes, out_ctrl layout, CSR ops, beat structs.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package decode_stage_pkg;

  localparam int XLEN_C = 32;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // out_ctrl layout:
  // {branch, jump[1:0], mem_read, mem_write, reg_write, to_reg, result_sel[1:0], alu_src, pc_add, alu_ctrl_op[1:0]}
  localparam int CTRL_W      = 13;
  localparam int CB_BRANCH   = 12;
  localparam int CB_JUMP_HI  = 11;
  localparam int CB_JUMP_LO  = 10;
  localparam int CB_MEM_RD   = 9;
  localparam int CB_MEM_WR   = 8;
  localparam int CB_REG_WR   = 7;
  localparam int CB_TO_REG   = 6;
  localparam int CB_RES_HI   = 5;
  localparam int CB_RES_LO   = 4;
  localparam int CB_ALU_SRC  = 3;
  localparam int CB_PC_ADD   = 2;
  localparam int CB_ALUOP_HI = 1;
  localparam int CB_ALUOP_LO = 0;

  // jump field
  localparam logic [1:0] JUMP_JAL  = 2'b01;
  localparam logic [1:0] JUMP_JALR = 2'b11;

  // result_sel field: which value is written back to rd
  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_IMM  = 2'b01;
  localparam logic [1:0] RES_LINK = 2'b10;  // pc + 4
  localparam logic [1:0] RES_CSR  = 2'b11;

  // alu_ctrl_op field
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_FN  = 2'b10;

  // CSR operations (equal to SYSTEM funct3)
  localparam logic [2:0] CSR_NONE = 3'b000;
  localparam logic [2:0] CSR_RW   = 3'b001;
  localparam logic [2:0] CSR_RS   = 3'b010;
  localparam logic [2:0] CSR_RC   = 3'b011;
  localparam logic [2:0] CSR_RWI  = 3'b101;
  localparam logic [2:0] CSR_RSI  = 3'b110;
  localparam logic [2:0] CSR_RCI  = 3'b111;

  // Decoded control bundle produced by decode_ctrl
  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN_C-1:0] imm;
    logic [2:0]        csr;
    logic              illegal;
  } dec_t;

  // Raw register/function fields carried with each beat
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic       funct7_5;
  } fields_t;

endpackage

// File: rtl/decode_ctrl.sv
// Combinational RV32I decoder: instruction word -> {ctrl, imm, csr, illegal}.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing stage registers the result.
// Ports: i_instr (32b instruction word), o_dec (decoded bundle, dec_t).
// Build option: DECODE_CSR_EN adds SYSTEM/CSR decode; when undefined every SYSTEM word is illegal.
module decode_ctrl
  import decode_stage_pkg::*;
(
  input  logic [31:0] i_instr,
  output dec_t        o_dec
);

  logic [6:0]  w_opc;
  logic [4:0]  w_rd;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;

  assign w_opc   = i_instr[6:0];
  assign w_rd    = i_instr[11:7];
  assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign w_imm_u = {i_instr[31:12], 12'b0};
  assign w_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

`ifdef DECODE_CSR_EN
  logic [2:0] w_f3;
  assign w_f3 = i_instr[14:12];
`endif

  always_comb begin
    o_dec     = '0;
    o_dec.csr = CSR_NONE;
    case (w_opc)
      OPC_LUI: begin
        o_dec.ctrl[CB_REG_WR]            = 1'b1;
        o_dec.ctrl[CB_RES_HI:CB_RES_LO]  = RES_IMM;
        o_dec.ctrl[CB_ALU_SRC]           = 1'b1;
        o_dec.imm                        = w_imm_u;
      end
      OPC_AUIPC: begin
        // ALU computes pc + imm
        o_dec.ctrl[CB_REG_WR]            = 1'b1;
        o_dec.ctrl[CB_RES_HI:CB_RES_LO]  = RES_ALU;
        o_dec.ctrl[CB_ALU_SRC]           = 1'b1;
        o_dec.ctrl[CB_PC_ADD]            = 1'b1;
        o_dec.imm                        = w_imm_u;
      end
      OPC_JAL: begin
        o_dec.ctrl[CB_JUMP_HI:CB_JUMP_LO] = JUMP_JAL;
        o_dec.ctrl[CB_REG_WR]             = 1'b1;
        o_dec.ctrl[CB_RES_HI:CB_RES_LO]   = RES_LINK;
        o_dec.imm                         = w_imm_j;
      end
      OPC_JALR: begin
        o_dec.ctrl[CB_JUMP_HI:CB_JUMP_LO] = JUMP_JALR;
        o_dec.ctrl[CB_REG_WR]             = 1'b1;
        o_dec.ctrl[CB_RES_HI:CB_RES_LO]   = RES_LINK;
        o_dec.ctrl[CB_ALU_SRC]            = 1'b1;
        o_dec.imm                         = w_imm_i;
      end
      OPC_BRANCH: begin
        o_dec.ctrl[CB_BRANCH]                = 1'b1;
        o_dec.ctrl[CB_ALUOP_HI:CB_ALUOP_LO]  = ALUOP_BR;
        o_dec.imm                            = w_imm_b;
      end
      OPC_LOAD: begin
        o_dec.ctrl[CB_MEM_RD]                = 1'b1;
        o_dec.ctrl[CB_REG_WR]                = 1'b1;
        o_dec.ctrl[CB_TO_REG]                = 1'b1;
        o_dec.ctrl[CB_ALU_SRC]               = 1'b1;
        o_dec.ctrl[CB_ALUOP_HI:CB_ALUOP_LO]  = ALUOP_ADD;
        o_dec.imm                            = w_imm_i;
      end
      OPC_STORE: begin
        o_dec.ctrl[CB_MEM_WR]                = 1'b1;
        o_dec.ctrl[CB_ALU_SRC]               = 1'b1;
        o_dec.ctrl[CB_ALUOP_HI:CB_ALUOP_LO]  = ALUOP_ADD;
        o_dec.imm                            = w_imm_s;
      end
      OPC_OPIMM: begin
        o_dec.ctrl[CB_REG_WR]                = 1'b1;
        o_dec.ctrl[CB_ALU_SRC]               = 1'b1;
        o_dec.ctrl[CB_ALUOP_HI:CB_ALUOP_LO]  = ALUOP_FN;
        o_dec.imm                            = w_imm_i;
      end
      OPC_OP: begin
        o_dec.ctrl[CB_REG_WR]                = 1'b1;
        o_dec.ctrl[CB_ALUOP_HI:CB_ALUOP_LO]  = ALUOP_FN;
      end
      OPC_FENCE: begin
        // Single-hart in-order core: fence is a plain NOP here.
      end
`ifdef DECODE_CSR_EN
      OPC_SYSTEM: begin
        case (w_f3)
          CSR_RW, CSR_RS, CSR_RC: begin
            o_dec.csr                        = w_f3;
            o_dec.ctrl[CB_REG_WR]            = 1'b1;
            o_dec.ctrl[CB_RES_HI:CB_RES_LO]  = RES_CSR;
            o_dec.ctrl[CB_ALU_SRC]           = w_f3[2];
          end
          CSR_RWI, CSR_RSI, CSR_RCI: begin
            // Immediate forms: zimm lives in the rs1 field
            o_dec.csr                        = w_f3;
            o_dec.ctrl[CB_REG_WR]            = 1'b1;
            o_dec.ctrl[CB_RES_HI:CB_RES_LO]  = RES_CSR;
            o_dec.ctrl[CB_ALU_SRC]           = w_f3[2];
            o_dec.imm                        = {27'b0, i_instr[19:15]};
          end
          default: o_dec.illegal = 1'b1;  // ecall/ebreak/mret etc. and funct3=100
        endcase
      end
`endif
      default: o_dec.illegal = 1'b1;
    endcase

    // Compressed/short encodings are not supported
    if (i_instr[1:0] != 2'b11) begin
      o_dec.illegal = 1'b1;
    end

    // Illegal beats still flow downstream but must not have side effects
    if (o_dec.illegal) begin
      o_dec.ctrl = '0;
      o_dec.imm  = '0;
      o_dec.csr  = CSR_NONE;
    end

    if (w_rd == 5'd0) begin
      o_dec.ctrl[CB_REG_WR] = 1'b0;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered valid/ready RV32I decode stage with one-entry skid buffer and flush.
// Latency: 1 cycle (beat accepted at edge N is presented after edge N); 1 beat/cycle throughput.
// Backpressure: a stalled output diverts one extra beat into the skid register; in_ready = !skid_valid (registered).
// Ports: clk/rst_n; in_valid/in_ready/in_instr/in_pc upstream; flush; out_valid/out_ready and decoded
//        out_pc, out_rs1/rs2/rd, out_funct3, out_funct7_5, out_imm, out_ctrl, out_csr, out_illegal downstream.
// Build option: DECODE_CSR_EN enables CSR decode (out_csr is constant 0 otherwise).
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int PC_W = 32,
  parameter int XLEN = 32   // only 32 supported
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [4:0]        out_rd,
  output logic [2:0]        out_funct3,
  output logic              out_funct7_5,
  output logic [XLEN-1:0]   out_imm,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [2:0]        out_csr,
  output logic              out_illegal
);

  dec_t          w_in_dec;
  fields_t       w_in_fld;
  logic          w_acc;
  logic          w_main_free;

  logic          r_out_vld;
  logic          r_skid_vld;
  logic [PC_W-1:0] r_main_pc;
  fields_t       r_main_fld;
  dec_t          r_main_dec;
  logic [PC_W-1:0] r_skid_pc;
  fields_t       r_skid_fld;
  dec_t          r_skid_dec;

  decode_ctrl u_decode_ctrl (
    .i_instr (in_instr),
    .o_dec   (w_in_dec)
  );

  assign w_in_fld = {in_instr[19:15], in_instr[24:20], in_instr[11:7], in_instr[14:12], in_instr[30]};

  // Purely registered ready: no combinational path from out_ready
  assign in_ready    = !r_skid_vld;
  assign w_acc       = in_valid && in_ready;
  // Main register can take a new beat this edge if empty or being consumed
  assign w_main_free = !r_out_vld || out_ready;

  // Valid bits. Flush wins over everything, including a same-cycle accept;
  // a beat transferring downstream during flush has already been consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld  <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (flush) begin
      r_out_vld  <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (w_main_free) begin
      if (r_skid_vld) begin
        r_out_vld  <= 1'b1;
        r_skid_vld <= 1'b0;
      end else begin
        r_out_vld  <= w_acc;
      end
    end else if (w_acc) begin
      r_skid_vld <= 1'b1;
    end
  end

  // Data registers: main only changes when free, which keeps out_* stable under stall.
  // Skid beat has priority over the input; in_ready is low whenever skid is full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_pc  <= '0;
      r_main_fld <= '0;
      r_main_dec <= '0;
      r_skid_pc  <= '0;
      r_skid_fld <= '0;
      r_skid_dec <= '0;
    end else if (w_main_free) begin
      if (r_skid_vld) begin
        r_main_pc  <= r_skid_pc;
        r_main_fld <= r_skid_fld;
        r_main_dec <= r_skid_dec;
      end else if (w_acc) begin
        r_main_pc  <= in_pc;
        r_main_fld <= w_in_fld;
        r_main_dec <= w_in_dec;
      end
    end else if (w_acc) begin
      r_skid_pc  <= in_pc;
      r_skid_fld <= w_in_fld;
      r_skid_dec <= w_in_dec;
    end
  end

  assign out_valid    = r_out_vld;
  assign out_pc       = r_main_pc;
  assign out_rs1      = r_main_fld.rs1;
  assign out_rs2      = r_main_fld.rs2;
  assign out_rd       = r_main_fld.rd;
  assign out_funct3   = r_main_fld.funct3;
  assign out_funct7_5 = r_main_fld.funct7_5;
  assign out_imm      = r_main_dec.imm;
  assign out_ctrl     = r_main_dec.ctrl;
  assign out_csr      = r_main_dec.csr;
  assign out_illegal  = r_main_dec.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: scoreboard of expected beats, per-scenario tasks.
module tb_decode_stage;
  import decode_stage_pkg::*;

  localparam int PC_W = 32;
  localparam int XLEN = 32;
  localparam int NVEC = 14;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [31:0]       in_instr = '0;
  logic [PC_W-1:0]   in_pc = '0;
  logic              flush = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [PC_W-1:0]   out_pc;
  logic [4:0]        out_rs1, out_rs2, out_rd;
  logic [2:0]        out_funct3;
  logic              out_funct7_5;
  logic [XLEN-1:0]   out_imm;
  logic [CTRL_W-1:0] out_ctrl;
  logic [2:0]        out_csr;
  logic              out_illegal;

  decode_stage #(.PC_W(PC_W), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_funct3(out_funct3), .out_funct7_5(out_funct7_5),
    .out_imm(out_imm), .out_ctrl(out_ctrl), .out_csr(out_csr), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [12:0] ctrl;
    logic [2:0]  csr;
    logic        ill;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] next_pc = 32'h0000_1000;

  logic [31:0] v_instr[NVEC];
  logic [4:0]  v_rd[NVEC];
  logic [31:0] v_imm[NVEC];
  logic [12:0] v_ctrl[NVEC];
  logic [2:0]  v_csr[NVEC];
  logic        v_ill[NVEC];

  task automatic set_vec(input int i, input logic [31:0] ins, input logic [4:0] rd,
                         input logic [31:0] imm, input logic [12:0] ctrl,
                         input logic [2:0] csr, input logic ill);
    v_instr[i] = ins; v_rd[i] = rd; v_imm[i] = imm;
    v_ctrl[i] = ctrl; v_csr[i] = csr; v_ill[i] = ill;
  endtask

  // Hand-derived expectations; ctrl bits are
  // {branch, jump[1:0], mem_rd, mem_wr, reg_wr, to_reg, res_sel[1:0], alu_src, pc_add, aluop[1:0]}
  task automatic init_vectors();
    set_vec(0,  32'h00500093, 5'd1,  32'h0000_0005, 13'h08A, 3'b000, 1'b0); // addi x1,x0,5
    set_vec(1,  32'hFE000EE3, 5'd29, 32'hFFFF_FFFC, 13'h1001, 3'b000, 1'b0); // beq x0,x0,-4
    set_vec(2,  32'h00000013, 5'd0,  32'h0000_0000, 13'h00A, 3'b000, 1'b0); // nop: reg_write off
    set_vec(3,  32'h00000000, 5'd0,  32'h0000_0000, 13'h000, 3'b000, 1'b1); // low bits != 11
    set_vec(4,  32'h0000007F, 5'd0,  32'h0000_0000, 13'h000, 3'b000, 1'b1); // unknown opcode
`ifdef DECODE_CSR_EN
    set_vec(5,  32'h300110F3, 5'd1,  32'h0000_0000, 13'h0B0, 3'b001, 1'b0); // csrrw x1,mstatus,x2
`else
    set_vec(5,  32'h300110F3, 5'd1,  32'h0000_0000, 13'h000, 3'b000, 1'b1);
`endif
    set_vec(6,  32'h123452B7, 5'd5,  32'h1234_5000, 13'h098, 3'b000, 1'b0); // lui x5,0x12345
    set_vec(7,  32'h00812183, 5'd3,  32'h0000_0008, 13'h2C8, 3'b000, 1'b0); // lw x3,8(x2)
    set_vec(8,  32'hFE512E23, 5'd28, 32'hFFFF_FFFC, 13'h108, 3'b000, 1'b0); // sw x5,-4(x2)
    set_vec(9,  32'h008000EF, 5'd1,  32'h0000_0008, 13'h4A0, 3'b000, 1'b0); // jal x1,+8
    set_vec(10, 32'h002081B3, 5'd3,  32'h0000_0000, 13'h082, 3'b000, 1'b0); // add x3,x1,x2
    set_vec(11, 32'h00001217, 5'd4,  32'h0000_1000, 13'h08C, 3'b000, 1'b0); // auipc x4,1
    set_vec(12, 32'h00008067, 5'd0,  32'h0000_0000, 13'hC28, 3'b000, 1'b0); // jalr x0,0(x1)
    set_vec(13, 32'h0FF0000F, 5'd0,  32'h0000_0000, 13'h000, 3'b000, 1'b0); // fence
  endtask

  task automatic push_exp(input int i, input logic [31:0] pc);
    exp_t e;
    e.pc = pc; e.rd = v_rd[i]; e.imm = v_imm[i];
    e.ctrl = v_ctrl[i]; e.csr = v_csr[i]; e.ill = v_ill[i];
    sb_q.push_back(e);
  endtask

  // Offer one beat, hold it until accepted; push expectation if it should emerge.
  task automatic send(input int i, input logic expect_out, output int stalls);
    logic acc;
    acc = 1'b0;
    stalls = 0;
    in_valid = 1'b1; in_instr = v_instr[i]; in_pc = next_pc;
    while (!acc && stalls < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (!acc) stalls++;
    end
    if (!acc) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: idx %0d not accepted after %0d cycles, required accept", i, stalls);
    end else if (expect_out) begin
      push_exp(i, next_pc);
    end
    next_pc  = next_pc + 32'd4;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Scoreboard: compare every beat consumed downstream.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat: got pc %h, required no beat", out_pc);
      end else begin
        mon_e = sb_q.pop_front();
        if (out_pc !== mon_e.pc) begin
          n_fail++; $display("FAIL beat_pc: got %h required %h", out_pc, mon_e.pc);
        end
        n_tests++;
        if (out_rd !== mon_e.rd) begin
          n_fail++; $display("FAIL beat_rd pc %h: got %0d required %0d", mon_e.pc, out_rd, mon_e.rd);
        end
        n_tests++;
        if (out_imm !== mon_e.imm) begin
          n_fail++; $display("FAIL beat_imm pc %h: got %h required %h", mon_e.pc, out_imm, mon_e.imm);
        end
        n_tests++;
        if (out_ctrl !== mon_e.ctrl) begin
          n_fail++; $display("FAIL beat_ctrl pc %h: got %h required %h", mon_e.pc, out_ctrl, mon_e.ctrl);
        end
        n_tests++;
        if (out_csr !== mon_e.csr) begin
          n_fail++; $display("FAIL beat_csr pc %h: got %b required %b", mon_e.pc, out_csr, mon_e.csr);
        end
        n_tests++;
        if (out_illegal !== mon_e.ill) begin
          n_fail++; $display("FAIL beat_illegal pc %h: got %b required %b", mon_e.pc, out_illegal, mon_e.ill);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    n_tests++; if (out_ctrl !== 13'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h required 0", out_ctrl); end
    n_tests++; if (out_imm !== 32'h0) begin n_fail++; $display("FAIL reset_imm: got %h required 0", out_imm); end
    n_tests++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h required 0", out_pc); end
    n_tests++; if ({out_rs1, out_rs2, out_rd, out_funct3, out_funct7_5, out_csr, out_illegal} !== 23'h0) begin
      n_fail++; $display("FAIL reset_fields: got %h required 0",
                         {out_rs1, out_rs2, out_rd, out_funct3, out_funct7_5, out_csr, out_illegal});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Each vector alone; also checks one-cycle latency.
  task automatic test_decode();
    int st;
    out_ready = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      send(i, 1'b1, st);
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b1) begin
        n_fail++; $display("FAIL latency idx %0d: out_valid %b required 1", i, out_valid);
      end
      @(posedge clk); #1;
    end
    idle(2);
  endtask

  task automatic test_back_to_back();
    int st, tot;
    tot = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send((i * 5) % NVEC, 1'b1, st);
      tot += st;
    end
    n_tests++;
    if (tot !== 0) begin
      n_fail++; $display("FAIL throughput: %0d stall cycles with out_ready high, required 0", tot);
    end
    idle(3);
  endtask

  task automatic test_backpressure();
    logic [31:0] pc_a, pc_b, pc_c;
    int rdy_low;
    rdy_low = 0;
    out_ready = 1'b0;
    pc_a = next_pc; pc_b = next_pc + 4; pc_c = next_pc + 8;
    next_pc = next_pc + 12;
    in_valid = 1'b1; in_instr = v_instr[6]; in_pc = pc_a; push_exp(6, pc_a);
    @(posedge clk); #1;                                   // A -> main
    in_instr = v_instr[7]; in_pc = pc_b; push_exp(7, pc_b);
    @(negedge clk); if (!in_ready) rdy_low++;
    @(posedge clk); #1;                                   // B -> skid
    in_instr = v_instr[8]; in_pc = pc_c; push_exp(8, pc_c);
    @(negedge clk); if (!in_ready) rdy_low++;
    n_tests++; if (out_pc !== pc_a || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL stall_hold1: got pc %h vld %b required pc %h vld 1", out_pc, out_valid, pc_a);
    end
    @(posedge clk); #1;                                   // still stalled
    out_ready = 1'b1;
    @(negedge clk); if (!in_ready) rdy_low++;
    n_tests++; if (out_pc !== pc_a || out_imm !== v_imm[6]) begin
      n_fail++; $display("FAIL stall_hold2: got pc %h imm %h required pc %h imm %h", out_pc, out_imm, pc_a, v_imm[6]);
    end
    @(posedge clk); #1;                                   // A out, skid B -> main
    @(negedge clk); if (!in_ready) rdy_low++;
    n_tests++; if (out_pc !== pc_b || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL skid_promote: got pc %h rdy %b required pc %h rdy 1", out_pc, in_ready, pc_b);
    end
    @(posedge clk); #1;                                   // C accepted
    in_valid = 1'b0;
    @(negedge clk); if (!in_ready) rdy_low++;
    n_tests++; if (out_pc !== pc_c) begin
      n_fail++; $display("FAIL skid_order: got pc %h required %h", out_pc, pc_c);
    end
    n_tests++; if (rdy_low !== 2) begin
      n_fail++; $display("FAIL in_ready_low_cycles: got %0d required 2", rdy_low);
    end
    idle(3);
  endtask

  task automatic test_flush();
    int st;
    // Skid full, flush with a beat offered
    out_ready = 1'b0;
    send(0, 1'b0, st);
    send(1, 1'b0, st);
    flush = 1'b1; in_valid = 1'b1; in_instr = v_instr[2]; in_pc = next_pc; next_pc += 4;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_skid: got vld %b rdy %b required vld 0 rdy 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    idle(3);
    // Main only, flush while a beat is accepted (in_ready high)
    out_ready = 1'b0;
    send(6, 1'b0, st);
    flush = 1'b1; in_valid = 1'b1; in_instr = v_instr[7]; in_pc = next_pc; next_pc += 4;
    @(negedge clk);
    n_tests++; if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_accept_rdy: got %b required 1", in_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_drop: got vld %b required 0", out_valid);
    end
    idle(3);
    // Flush with out_ready high: current beat transfers, then empty
    send(9, 1'b1, st);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_transfer: got vld %b required 0", out_valid);
    end
    idle(2);
  endtask

  task automatic test_reset_midstream();
    int st;
    out_ready = 1'b0;
    send(10, 1'b0, st);
    send(11, 1'b0, st);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid: got vld %b rdy %b pc %h required 0 1 0", out_valid, in_ready, out_pc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    idle(3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    init_vectors();
    test_reset();
    test_decode();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: %0d beats missing, required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
